// File: rtl/fifo_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_pkg
//
// Shared definitions for the FIFO read-side stream adapter:
//   - buf_state_e : occupancy state of the 2-entry skid buffer
//   - SKID_DEPTH  : number of skid buffer entries
//   - state_occ() : maps a buffer state to its numeric occupancy
// -----------------------------------------------------------------------------
package fifo_stream_pkg;

    localparam int SKID_DEPTH = 2;

    // Encoding equals occupancy, so the state can be used directly as a count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    function automatic logic [1:0] state_occ(input buf_state_e s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
//
// Two-entry skid buffer holding words captured from the FIFO read port.
// Slot 0 is always the head (oldest word); slot 1 is only used in state TWO.
//
// Ports:
//   clock      in   : clock, everything on posedge
//   reset      in   : synchronous active-high reset
//   cap_valid  in   : capture cap_data on this edge
//   cap_data   in   : word arriving from the FIFO
//   pop        in   : head word is consumed on this edge
//   head_data  out  : head word (0 after reset)
//   head_valid out  : buffer holds at least one word
//   occ        out  : occupancy 0/1/2
// -----------------------------------------------------------------------------
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cap_valid,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occ
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [WIDTH-1:0] slot_q [SKID_DEPTH];
    logic [WIDTH-1:0] slot_d [SKID_DEPTH];
    logic             pop_eff;

    // A pop from an empty buffer is meaningless; ignore it defensively.
    assign pop_eff = pop && (state_q != EMPTY);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture adds one, pop removes one, both cancel out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (cap_valid) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (cap_valid && !pop_eff) begin
                    state_d = TWO;
                end else if (!cap_valid && pop_eff) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (!cap_valid && pop_eff) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        occ        = state_occ(state_q);
        head_valid = (state_q != EMPTY);
        head_data  = slot_q[0];
    end

    // Data path. The issue logic upstream guarantees no capture lands while
    // the buffer is full without a simultaneous pop, so a capture in TWO
    // without pop is simply dropped rather than overwriting live data.
    always_comb begin
        slot_d = slot_q;
        case (state_q)
            EMPTY: begin
                if (cap_valid) begin
                    slot_d[0] = cap_data;
                end
            end
            ONE: begin
                if (cap_valid && pop_eff) begin
                    // Old head leaves; the new word becomes the head directly.
                    slot_d[0] = cap_data;
                end else if (cap_valid) begin
                    slot_d[1] = cap_data;
                end
            end
            TWO: begin
                if (pop_eff) begin
                    slot_d[0] = slot_q[1];
                    if (cap_valid) begin
                        slot_d[1] = cap_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a synchronous FIFO with one-cycle registered read latency and
// presents the words as a valid/ready stream. A 2-entry skid buffer absorbs
// the word that is already in flight when downstream applies backpressure,
// so one word per cycle is sustained without loss.
//
// Ports:
//   clock      in   : clock, everything on posedge
//   reset      in   : synchronous active-high reset
//   fifo_empty in   : FIFO empty flag, used combinationally
//   data_outp  in   : FIFO read data, valid the cycle after read_en
//   read_en    out  : pop strobe to the FIFO (combinational)
//   out_data   out  : stream data (head of skid buffer)
//   out_valid  out  : stream valid
//   out_ready  in   : downstream ready
//   rd_count   out  : completed stream transfers, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] data_outp,
    output logic             read_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rd_count
);

    logic             inflight_q;
    logic             inflight_d;
    logic [CNT_W-1:0] rd_count_q;
    logic [CNT_W-1:0] rd_count_d;
    logic [1:0]       occ;
    logic             pop;
    logic [2:0]       committed;

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clock      (clock),
        .reset      (reset),
        .cap_valid  (inflight_q),
        .cap_data   (data_outp),
        .pop        (pop),
        .head_data  (out_data),
        .head_valid (out_valid),
        .occ        (occ)
    );

    always_comb begin
        pop = out_valid && out_ready;
        // Entries that will be occupied after this edge if no new read is
        // issued: buffered words plus the in-flight word minus a transfer.
        // occ is never 0 while pop is 1, so this cannot underflow.
        committed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        read_en   = !reset && !fifo_empty && (committed < 3'(SKID_DEPTH));
        // A read issued now returns data on the next cycle; a word that was
        // in flight is captured on this edge, so the flag simply follows
        // read_en.
        inflight_d = read_en;
        rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       fifo_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       out_ready;

    logic       fifo_empty;
    logic [7:0] data_outp;

    logic       read_en;
    logic       out_valid;
    logic [7:0] out_data;
    logic [15:0] rd_count;

    logic       read_en_w;
    logic       out_valid_w;
    logic [7:0] out_data_w;
    logic [3:0] rd_count_w;

    fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .data_outp  (data_outp),
        .read_en    (read_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_count   (rd_count)
    );

    // Narrow-counter twin; sees identical inputs so it tracks the main DUT.
    fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut_w (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .data_outp  (data_outp),
        .read_en    (read_en_w),
        .out_data   (out_data_w),
        .out_valid  (out_valid_w),
        .out_ready  (out_ready),
        .rd_count   (rd_count_w)
    );

    // Behavioural synchronous FIFO with one-cycle registered read.
    logic [7:0] mem [64];
    logic [5:0] wp, rp;
    int         cnt;
    logic       fifo_pop;
    assign fifo_empty = (cnt == 0);
    assign fifo_pop   = read_en && (cnt != 0);

    always @(posedge clock) begin
        if (fifo_rst) begin
            wp <= '0; rp <= '0; cnt <= 0; data_outp <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp <= wp + 6'd1;
            end
            if (fifo_pop) begin
                data_outp <= mem[rp];
                rp <= rp + 6'd1;
            end
            cnt <= cnt + (wr_en ? 1 : 0) - (fifo_pop ? 1 : 0);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        s_read_en, s_out_valid, s_inflight;
    logic [7:0]  s_out_data;
    logic [15:0] s_rd_count;
    logic [3:0]  s_rd_count_w;
    logic [1:0]  s_state;

    logic [7:0] rx[$];
    int         rx_cyc[$];
    logic [3:0] rxw_cnt[$];
    int         re_pulses;
    int         re_while_empty;

    // Inputs are set at the falling edge; sample 1 time unit later, which is
    // exactly what the next rising edge will see, then advance one cycle.
    task automatic tick();
        #1;
        s_read_en    = read_en;
        s_out_valid  = out_valid;
        s_out_data   = out_data;
        s_rd_count   = rd_count;
        s_rd_count_w = rd_count_w;
        s_state      = dut.u_skid.state_q;
        s_inflight   = dut.inflight_q;
        if (read_en === 1'b1) re_pulses++;
        if (read_en === 1'b1 && fifo_empty === 1'b1) re_while_empty++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            rx.push_back(out_data);
            rx_cyc.push_back(cyc);
            rxw_cnt.push_back(rd_count_w);
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic clear_logs();
        rx.delete();
        rx_cyc.delete();
        rxw_cnt.delete();
        re_pulses = 0;
        re_while_empty = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; fifo_rst = 1'b1; wr_en = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0; fifo_rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1; fifo_rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; out_ready = 1'b0;
        tick();
        fifo_rst = 1'b0;
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        n_checks++;
        if (s_read_en !== 1'b0 || s_out_valid !== 1'b0 || s_out_data !== 8'h00 || s_rd_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got read_en=%b out_valid=%b out_data=%h rd_count=%0d, expected 0/0/00/0",
                     s_read_en, s_out_valid, s_out_data, s_rd_count);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (s_read_en !== 1'b0 || s_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got read_en=%b out_valid=%b, expected 0/0", k, s_read_en, s_out_valid);
            end
        end
        reset = 1'b0; out_ready = 1'b1;
        clear_logs();
        tick();
        n_checks++;
        if (s_read_en !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_read_en: got %b expected 1", s_read_en);
        end
        tick();
        n_checks++;
        if (s_out_valid !== 1'b0 || s_read_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_latency1: got out_valid=%b read_en=%b expected 0/0", s_out_valid, s_read_en);
        end
        tick();
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'h11) begin
            n_fail++; $display("FAIL reset_first_word: got out_valid=%b out_data=%h expected 1/11", s_out_valid, s_out_data);
        end
        tick();
        n_checks++;
        if (s_out_valid !== 1'b0 || s_rd_count !== 16'd1) begin
            n_fail++; $display("FAIL reset_after_word: got out_valid=%b rd_count=%0d expected 0/1", s_out_valid, s_rd_count);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (rx.size() != 16) begin
            n_fail++; $display("FAIL stream_count: got %0d words expected 16", rx.size());
        end
        for (int i = 0; i < rx.size() && i < 16; i++) begin
            n_checks++;
            if (rx[i] !== 8'(i + 1) || rx_cyc[i] != rx_cyc[0] + i) begin
                n_fail++;
                $display("FAIL stream_word[%0d]: got %h at cycle offset %0d expected %h at offset %0d",
                         i, rx[i], rx_cyc[i] - rx_cyc[0], 8'(i + 1), i);
            end
        end
        n_checks++;
        if (s_rd_count !== 16'd16) begin
            n_fail++; $display("FAIL stream_rd_count: got %0d expected 16", s_rd_count);
        end
        n_checks++;
        if (re_while_empty != 0) begin
            n_fail++; $display("FAIL stream_read_when_empty: got %0d cycles expected 0", re_while_empty);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            tick();
        end
        wr_en = 1'b0; reset = 1'b0; out_ready = 1'b1;
        clear_logs();
        for (int k = 0; k < 4; k++) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (s_read_en !== 1'b0 || s_out_valid !== 1'b1 || s_out_data !== 8'hA2) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got read_en=%b out_valid=%b out_data=%h expected 0/1/a2",
                         k, s_read_en, s_out_valid, s_out_data);
            end
            if (k >= 1) begin
                n_checks++;
                if (s_state !== 2'(TWO)) begin
                    n_fail++; $display("FAIL bp_state[%0d]: got %0d expected 2", k, s_state);
                end
            end
        end
        n_checks++;
        if (rx.size() != 2) begin
            n_fail++; $display("FAIL bp_pre_stall_count: got %0d expected 2", rx.size());
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (s_read_en !== 1'b1) begin
            n_fail++; $display("FAIL bp_resume_read_en: got %b expected 1", s_read_en);
        end
        for (int k = 0; k < 15; k++) tick();
        n_checks++;
        if (rx.size() != 8) begin
            n_fail++; $display("FAIL bp_count: got %0d words expected 8", rx.size());
        end
        for (int i = 0; i < rx.size() && i < 8; i++) begin
            n_checks++;
            if (rx[i] !== 8'hA0 + 8'(i)) begin
                n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, rx[i], 8'hA0 + 8'(i));
            end
        end
        n_checks++;
        if (s_rd_count !== 16'd8) begin
            n_fail++; $display("FAIL bp_rd_count: got %0d expected 8", s_rd_count);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if (s_read_en !== 1'b1) begin
                    n_fail++; $display("FAIL single_read_en: got %b expected 1", s_read_en);
                end
            end
            if (k >= 3) begin
                n_checks++;
                if (s_out_valid !== 1'b1 || s_out_data !== 8'h5A) begin
                    n_fail++; $display("FAIL single_hold[%0d]: got out_valid=%b out_data=%h expected 1/5a", k, s_out_valid, s_out_data);
                end
            end
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_valid_drop: got %b expected 0", s_out_valid);
        end
        tick();
        tick();
        n_checks++;
        if (re_pulses != 1 || rx.size() != 1 || s_rd_count !== 16'd1) begin
            n_fail++; $display("FAIL single_summary: got pulses=%0d words=%0d rd_count=%0d expected 1/1/1",
                               re_pulses, rx.size(), s_rd_count);
        end else begin
            n_checks++;
            if (rx[0] !== 8'h5A) begin
                n_fail++; $display("FAIL single_word: got %h expected 5a", rx[0]);
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (rx.size() != 17) begin
            n_fail++; $display("FAIL wrap_count: got %0d words expected 17", rx.size());
        end else begin
            n_checks++;
            if (rxw_cnt[15] !== 4'd15 || rxw_cnt[16] !== 4'd0 || s_rd_count_w !== 4'd1) begin
                n_fail++; $display("FAIL wrap_sequence: got %0d->%0d->%0d expected 15->0->1",
                                   rxw_cnt[15], rxw_cnt[16], s_rd_count_w);
            end
            n_checks++;
            if (rx[16] !== 8'h40) begin
                n_fail++; $display("FAIL wrap_last_word: got %h expected 40", rx[16]);
            end
        end
        n_checks++;
        if (s_rd_count !== 16'd17) begin
            n_fail++; $display("FAIL wrap_wide_count: got %0d expected 17", s_rd_count);
        end
    endtask

    // Continues from the previous test so rd_count is non-zero beforehand.
    task automatic test_reset_mid();
        clear_logs();
        out_ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'h71;
        tick();
        wr_data = 8'h72;
        tick();
        wr_en = 1'b0;
        tick();
        n_checks++;
        if (s_read_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_second_read: got %b expected 1", s_read_en);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (s_state !== 2'(ONE) || s_inflight !== 1'b1 || s_read_en !== 1'b0 || s_rd_count !== 16'd17) begin
            n_fail++; $display("FAIL mid_pre_reset: got state=%0d inflight=%b read_en=%b rd_count=%0d expected 1/1/0/17",
                               s_state, s_inflight, s_read_en, s_rd_count);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (s_out_valid !== 1'b0 || s_rd_count !== 16'd0 || s_state !== 2'(EMPTY) || s_inflight !== 1'b0) begin
                n_fail++; $display("FAIL mid_in_reset[%0d]: got out_valid=%b rd_count=%0d state=%0d inflight=%b expected 0/0/0/0",
                                   k, s_out_valid, s_rd_count, s_state, s_inflight);
            end
        end
        reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (s_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_after_reset[%0d]: got out_valid=%b expected 0", k, s_out_valid);
            end
        end
        n_checks++;
        if (rx.size() != 0) begin
            n_fail++; $display("FAIL mid_discard: got %0d words delivered expected 0", rx.size());
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_single_word();
        test_counter_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
